// File: rtl/spi_avalon_bridge.sv
// rtl/spi_avalon_bridge.sv - SPI mode-0 slave framing 32-bit Avalon-MM master reads/writes.
// Optional waitrequest timeout compiled in with SPI_AVALON_TIMEOUT_EN.
module spi_avalon_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] avalon_master_address,
    output logic        avalon_master_write,
    output logic [31:0] avalon_master_writedata,
    output logic        avalon_master_read,
    input  logic [31:0] avalon_master_readdata,
    input  logic        avalon_master_waitrequest,
    output logic        busy,
    output logic        bus_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    localparam logic [1:0] FR_NONE = 2'd0;
    localparam logic [1:0] FR_CMD  = 2'd1;
    localparam logic [1:0] FR_WR   = 2'd2;
    localparam logic [1:0] FR_RD   = 2'd3;

    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  cs_sync_q, cs_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [1:0]  frame_q, frame_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [46:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        req_q, req_d;
    logic        req_rd_q, req_rd_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        rd_pending_q, rd_pending_d;
    logic        rd_valid_q, rd_valid_d;
    logic [1:0]  state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_err_q, bus_err_d;
`ifdef SPI_AVALON_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

    logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [47:0] rx_next;
    logic [31:0] tx_src;
    logic        done;
    logic [31:0] result;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], spi_sclk};
        cs_sync_d    = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d  = {mosi_sync_q[0], spi_mosi};
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        req_d        = 1'b0;
        req_rd_d     = req_rd_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        rd_pending_d = rd_pending_q;
        rd_valid_d   = rd_valid_q;
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bus_err_d    = bus_err_q;
        rx_next      = {rx_q, mosi_sync_q[1]};
        tx_src       = rd_valid_q ? tx_q : 32'hFFFF_FFFF;
        done         = 1'b0;
        result       = avalon_master_readdata;
`ifdef SPI_AVALON_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        if (cs_rise) begin
            frame_d      = FR_NONE;
            rd_pending_d = 1'b0;
            miso_d       = 1'b0;
        end else if (cs_fall) begin
            frame_d      = FR_CMD;
            bit_cnt_d    = 7'd0;
            rd_pending_d = 1'b0;
            rd_valid_d   = 1'b0;
            miso_d       = 1'b0;
        end else if (frame_q != FR_NONE) begin
            if (sclk_rise) begin
                rx_d = rx_next[46:0];
                if (bit_cnt_q != 7'h7f) begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
                if (frame_q == FR_CMD && bit_cnt_q == 7'd7) begin
                    case (rx_next[7:0])
                        8'h80:   frame_d = FR_WR;
                        8'h00:   frame_d = FR_RD;
                        default: frame_d = FR_NONE;
                    endcase
                end
                if ((frame_q == FR_RD && bit_cnt_q == 7'd23) ||
                    (frame_q == FR_WR && bit_cnt_q == 7'd55)) begin
                    // A new request cannot be queued behind a live access.
                    if (state_q != ST_IDLE || req_q) begin
                        bus_err_d = 1'b1;
                    end else begin
                        req_d        = 1'b1;
                        req_rd_d     = (frame_q == FR_RD);
                        req_addr_d   = (frame_q == FR_RD) ? rx_next[15:0] : rx_next[47:32];
                        req_wdata_d  = rx_next[31:0];
                        rd_pending_d = (frame_q == FR_RD);
                    end
                end
            end
            if (sclk_fall) begin
                if (frame_q == FR_RD && bit_cnt_q == 7'd32) begin
                    // Data phase starts: a read still outstanding is reported as an error.
                    if (!rd_valid_q) begin
                        bus_err_d = 1'b1;
                    end
                    rd_pending_d = 1'b0;
                    miso_d       = tx_src[31];
                    tx_d         = {tx_src[30:0], 1'b0};
                end else if (frame_q == FR_RD && bit_cnt_q > 7'd32 && bit_cnt_q < 7'd64) begin
                    miso_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_q) begin
                    state_d = req_rd_q ? ST_RD : ST_WR;
                    read_d  = req_rd_q;
                    write_d = ~req_rd_q;
                    addr_d  = req_addr_q;
                    if (!req_rd_q) begin
                        wdata_d = req_wdata_q;
                    end
`ifdef SPI_AVALON_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                end
            end
            ST_RD, ST_WR: begin
                if (!avalon_master_waitrequest) begin
                    done = 1'b1;
`ifdef SPI_AVALON_TIMEOUT_EN
                end else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    done      = 1'b1;
                    result    = 32'hDEAD_BEEF;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result only lands if the frame that issued the read still wants it.
        if (done) begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
            if (state_q == ST_RD && rd_pending_d) begin
                tx_d         = result;
                rd_valid_d   = 1'b1;
                rd_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            frame_q      <= FR_NONE;
            bit_cnt_q    <= 7'd0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            req_q        <= 1'b0;
            req_rd_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus_err_q    <= 1'b0;
`ifdef SPI_AVALON_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            req_q        <= req_d;
            req_rd_q     <= req_rd_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            rd_pending_q <= rd_pending_d;
            rd_valid_q   <= rd_valid_d;
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bus_err_q    <= bus_err_d;
`ifdef SPI_AVALON_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign spi_miso                = miso_q;
    assign avalon_master_read      = read_q;
    assign avalon_master_write     = write_q;
    assign avalon_master_address   = addr_q;
    assign avalon_master_writedata = wdata_q;
    assign busy                    = (state_q != ST_IDLE);
    assign bus_err                 = bus_err_q;
endmodule
